// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter: merges execute-stage writes with load returns
// through a 2-entry in-order load queue, with starvation back-pressure to execute.
module cpu_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_we_i,
  input  logic [3:0]  ex_index_i,
  input  logic [31:0] ex_result_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [3:0]  ld_index_i,
  input  logic [31:0] ld_result_i,
  output logic        register_write_enable_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] result_o,
  output logic        ex_stall_o,
  output logic [1:0]  pending_o
);

  localparam int         DEPTH      = 2;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic [3:0]  index;
    logic [31:0] data;
  } entry_t;

  entry_t      q_reg    [DEPTH];
  entry_t      q_next   [DEPTH];
  entry_t      q_squash [DEPTH];
  logic [1:0]  count_reg, count_next;
  logic [3:0]  starve_reg, starve_next;
  logic        stall_reg;
  logic        wr_en_reg, wr_en_next;
  logic [3:0]  wr_index_reg, wr_index_next;
  logic [31:0] wr_data_reg, wr_data_next;

  logic        ld_accept;
  logic        sel_pop;
  logic        sel_bypass;
  logic        push;
  logic        push_valid;
  logic [1:0]  push_pos;

  // Ready depends on registered occupancy only, so no input reaches it combinationally.
  assign ld_ready_o = (count_reg != 2'd2);
  assign ld_accept  = ld_valid_i & ld_ready_o;
  assign sel_pop    = !ex_we_i && (count_reg != 2'd0);
  assign sel_bypass = !ex_we_i && (count_reg == 2'd0) && ld_accept;
  assign push       = ld_accept && !sel_bypass;
  assign push_valid = !(ex_we_i && (ld_index_i == ex_index_i));
  assign push_pos   = count_reg - {1'b0, sel_pop};

  // An execute write supersedes any older queued load to the same register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
    assign q_squash[gi] = {q_reg[gi].valid & ~(ex_we_i && (q_reg[gi].index == ex_index_i)),
                           q_reg[gi].index, q_reg[gi].data};
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_next[i] = q_squash[i];
    end
    count_next = count_reg;
    if (sel_pop) begin
      q_next[0]  = q_squash[1];
      q_next[1]  = '0;
      count_next = count_reg - 2'd1;
    end
    if (push) begin
      q_next[push_pos[0]] = {push_valid, ld_index_i, ld_result_i};
      count_next          = count_next + 2'd1;
    end
  end

  always_comb begin
    wr_en_next    = 1'b0;
    wr_index_next = wr_index_reg;
    wr_data_next  = wr_data_reg;
    if (ex_we_i) begin
      wr_en_next    = 1'b1;
      wr_index_next = ex_index_i;
      wr_data_next  = ex_result_i;
    end else if (sel_pop) begin
      // A squashed head is consumed silently.
      if (q_reg[0].valid) begin
        wr_en_next    = 1'b1;
        wr_index_next = q_reg[0].index;
        wr_data_next  = q_reg[0].data;
      end
    end else if (sel_bypass) begin
      wr_en_next    = 1'b1;
      wr_index_next = ld_index_i;
      wr_data_next  = ld_result_i;
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if ((count_reg == 2'd0) || sel_pop) begin
      starve_next = 4'd0;
    end else if (ex_we_i && (starve_reg != STARVE_MAX)) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= '0;
      end
      count_reg    <= 2'd0;
      starve_reg   <= 4'd0;
      stall_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_index_reg <= 4'd0;
      wr_data_reg  <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= q_next[i];
      end
      count_reg    <= count_next;
      starve_reg   <= starve_next;
      stall_reg    <= (starve_reg == STARVE_MAX);
      wr_en_reg    <= wr_en_next;
      wr_index_reg <= wr_index_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  assign register_write_enable_o = wr_en_reg;
  assign register_write_index_o  = wr_index_reg;
  assign result_o                = wr_data_reg;
  assign ex_stall_o              = stall_reg;
  assign pending_o               = count_reg;

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Scoreboard bench for cpu_wb_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write strobe.
module tb_cpu_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_we_i = 1'b0;
  logic [3:0]  ex_index_i = '0;
  logic [31:0] ex_result_i = '0;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic [3:0]  ld_index_i = '0;
  logic [31:0] ld_result_i = '0;
  logic        register_write_enable_o;
  logic [3:0]  register_write_index_o;
  logic [31:0] result_o;
  logic        ex_stall_o;
  logic [1:0]  pending_o;

  cpu_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_we_i(ex_we_i), .ex_index_i(ex_index_i), .ex_result_i(ex_result_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_index_i(ld_index_i), .ld_result_i(ld_result_i),
    .register_write_enable_o(register_write_enable_o),
    .register_write_index_o(register_write_index_o),
    .result_o(result_o), .ex_stall_o(ex_stall_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [3:0] idx, input logic [31:0] data);
    wr_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic exw, input logic [3:0] exi, input logic [31:0] exr,
                       input logic ldv, input logic [3:0] ldi, input logic [31:0] ldr);
    ex_we_i     = exw;
    ex_index_i  = exi;
    ex_result_i = exr;
    ld_valid_i  = ldv;
    ld_index_i  = ldi;
    ld_result_i = ldr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every strobed write must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && register_write_enable_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got r%0d=0x%08h required no write",
                 register_write_index_o, result_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write r%0d = 0x%08h (expected r%0d = 0x%08h)",
                 register_write_index_o, result_o, e.idx, e.data);
        check("wr_index", 32'(register_write_index_o), 32'(e.idx));
        check("wr_data", result_o, e.data);
      end
    end
  end

  initial begin
    // Reset state
    #1 rst_i = 1'b0;
    #1;
    check("rst_enable", 32'(register_write_enable_o), 32'd0);
    check("rst_index", 32'(register_write_index_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_stall", 32'(ex_stall_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    check("rst_ready", 32'(ld_ready_o), 32'd1);
    step();
    step();
    rst_i = 1'b1;

    // Bypass
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hDEADBEEF);
    expect_wr(4'd3, 32'hDEADBEEF);
    step();
    idle();
    check("bypass_pending", 32'(pending_o), 32'd0);
    check("bypass_ready", 32'(ld_ready_o), 32'd1);
    step();

    // Collision: ex first, load one cycle later
    drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    expect_wr(4'd1, 32'h11);
    expect_wr(4'd2, 32'h22);
    step();
    idle();
    check("coll_pending1", 32'(pending_o), 32'd1);
    step();
    check("coll_pending0", 32'(pending_o), 32'd0);
    step();

    // Full queue under sustained ex traffic
    drive(1'b1, 4'd7, 32'hA0, 1'b1, 4'd8, 32'h80);
    expect_wr(4'd7, 32'hA0);
    step();
    check("full_pending1", 32'(pending_o), 32'd1);
    drive(1'b1, 4'd7, 32'hA1, 1'b1, 4'd9, 32'h90);
    expect_wr(4'd7, 32'hA1);
    step();
    check("full_pending2", 32'(pending_o), 32'd2);
    drive(1'b1, 4'd7, 32'hA2, 1'b1, 4'd10, 32'hAA);
    check("full_ready", 32'(ld_ready_o), 32'd0);
    expect_wr(4'd7, 32'hA2);
    step();
    check("full_hold", 32'(pending_o), 32'd2);
    idle();
    expect_wr(4'd8, 32'h80);
    expect_wr(4'd9, 32'h90);
    step();
    check("drain_pending1", 32'(pending_o), 32'd1);
    step();
    check("drain_pending0", 32'(pending_o), 32'd0);
    check("drain_stall", 32'(ex_stall_o), 32'd0);
    step();

    // Squash of a queued load by a younger ex write
    drive(1'b1, 4'd6, 32'h60, 1'b1, 4'd5, 32'h5A);
    expect_wr(4'd6, 32'h60);
    step();
    check("squash_queued", 32'(pending_o), 32'd1);
    drive(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0);
    expect_wr(4'd5, 32'h55);
    step();
    check("squash_pending", 32'(pending_o), 32'd1);
    idle();
    step();
    check("squash_enable", 32'(register_write_enable_o), 32'd0);
    check("squash_drained", 32'(pending_o), 32'd0);
    step();

    // Same-cycle ex and load to one register: load is the older one
    drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd4, 32'h4F);
    expect_wr(4'd4, 32'h44);
    step();
    check("same_pending", 32'(pending_o), 32'd1);
    idle();
    step();
    check("same_enable", 32'(register_write_enable_o), 32'd0);
    check("same_drained", 32'(pending_o), 32'd0);
    step();

    // Starvation
    drive(1'b1, 4'd1, 32'hB0, 1'b1, 4'd2, 32'hC0);
    expect_wr(4'd1, 32'hB0);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'd1, 32'hB0 + 32'(i), 1'b0, 4'd0, 32'd0);
      expect_wr(4'd1, 32'hB0 + 32'(i));
      step();
    end
    check("starve_not_yet", 32'(ex_stall_o), 32'd0);
    idle();
    expect_wr(4'd2, 32'hC0);
    step();
    check("starve_stall", 32'(ex_stall_o), 32'd1);
    check("starve_popped", 32'(pending_o), 32'd0);
    step();
    check("starve_release", 32'(ex_stall_o), 32'd0);
    step();

    // Reset mid-operation with a full queue and stall asserted (ex keeps writing while stalled)
    drive(1'b1, 4'd3, 32'hD0, 1'b1, 4'd11, 32'hB1);
    expect_wr(4'd3, 32'hD0);
    step();
    drive(1'b1, 4'd3, 32'hD1, 1'b1, 4'd12, 32'hB2);
    expect_wr(4'd3, 32'hD1);
    step();
    for (int i = 2; i <= 5; i++) begin
      drive(1'b1, 4'd3, 32'hD0 + 32'(i), 1'b0, 4'd0, 32'd0);
      expect_wr(4'd3, 32'hD0 + 32'(i));
      step();
    end
    check("pre_rst_stall", 32'(ex_stall_o), 32'd1);
    check("pre_rst_pending", 32'(pending_o), 32'd2);
    @(negedge clk_i);
    #1;
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 32'hEE);
    rst_i = 1'b0;
    #1;
    check("mid_rst_enable", 32'(register_write_enable_o), 32'd0);
    check("mid_rst_index", 32'(register_write_index_o), 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_stall", 32'(ex_stall_o), 32'd0);
    check("mid_rst_pending", 32'(pending_o), 32'd0);
    check("mid_rst_ready", 32'(ld_ready_o), 32'd1);
    step();
    idle();
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_pending", 32'(pending_o), 32'd0);

    // Arbitration resumes after reset
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'h12345678);
    expect_wr(4'd14, 32'h12345678);
    step();
    idle();
    check("resume_pending", 32'(pending_o), 32'd0);
    step();
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
